// File: rtl/instr_decode_if.sv
// Fetch/execute-side handshake and decoded-field bundle for instr_decode_stage.
// master = surrounding pipeline (fetch, execute, writeback); slave = the decode stage.
interface instr_decode_if #(
  parameter int ARQ   = 16,
  parameter int OPC_W = 3,
  parameter int RW    = 3
);
  localparam int IMM_W  = ARQ - OPC_W - RW;
  localparam int ADDR_W = ARQ - OPC_W;

  logic              instr_valid;
  logic [ARQ-1:0]    instr;
  logic              instr_ready;
  logic              flush;
  logic              dec_valid;
  logic              dec_ready;
  logic [OPC_W-1:0]  opcode;
  logic [RW-1:0]     rd;
  logic [RW-1:0]     rs1;
  logic [RW-1:0]     rs2;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] addr;
  logic              jop_lsb;
  logic              is_wr;
  logic              is_ld;
  logic              is_st;
  logic              is_cmp;
  logic              is_jmp;
  logic              wb_en;
  logic [RW-1:0]     wb_reg;
  logic              wb_flag;

  modport master (
    output instr_valid, instr, flush, dec_ready, wb_en, wb_reg, wb_flag,
    input  instr_ready, dec_valid, opcode, rd, rs1, rs2, imm, addr,
           jop_lsb, is_wr, is_ld, is_st, is_cmp, is_jmp
  );

  modport slave (
    input  instr_valid, instr, flush, dec_ready, wb_en, wb_reg, wb_flag,
    output instr_ready, dec_valid, opcode, rd, rs1, rs2, imm, addr,
           jop_lsb, is_wr, is_ld, is_st, is_cmp, is_jmp
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Decode stage: registers fetch word split into fields/class flags, 1-cycle latency, holds while execute stalls.
// RAW/flag scoreboard stalls issue until writeback only when ID_SCOREBOARD_EN is defined.
module instr_decode_stage #(
  parameter int ARQ   = 16,
  parameter int OPC_W = 3,
  parameter int RW    = 3
) (
  input logic           clk,
  input logic           rst,
  instr_decode_if.slave dif
);
  localparam int IMM_W  = ARQ - OPC_W - RW;
  localparam int ADDR_W = ARQ - OPC_W;
  localparam int NREG   = 1 << RW;

  localparam logic [OPC_W-1:0] OP_SET   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDPX  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MODEX = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_STPX  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_CMPEQ = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_JEQ   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(7);

  logic [OPC_W-1:0] in_opc;
  logic             in_wr, in_ld, in_st, in_cmp, in_jmp;

  logic              stage_valid;
  logic [OPC_W-1:0]  opc_q;
  logic [RW-1:0]     rd_q, rs1_q, rs2_q;
  logic [IMM_W-1:0]  imm_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q, ld_q, st_q, cmp_q, jmp_q;

  logic hazard, issue, accept;

  assign in_opc = dif.instr[ARQ-1 -: OPC_W];
  assign in_wr  = (in_opc == OP_SET) | (in_opc == OP_LDPX) | (in_opc == OP_MODEX) | (in_opc == OP_ADD);
  assign in_ld  = (in_opc == OP_LDPX);
  assign in_st  = (in_opc == OP_STPX);
  assign in_cmp = (in_opc == OP_CMPEQ);
  assign in_jmp = (in_opc == OP_JEQ) | (in_opc == OP_J);

  assign dif.dec_valid   = stage_valid & ~hazard;
  assign issue           = dif.dec_valid & dif.dec_ready;
  assign dif.instr_ready = ~stage_valid | issue;
  assign accept          = dif.instr_valid & dif.instr_ready;

  // flush takes priority over a concurrent accept: the incoming word is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      opc_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
      cmp_q       <= 1'b0;
      jmp_q       <= 1'b0;
    end else if (dif.flush) begin
      stage_valid <= 1'b0;
    end else if (accept) begin
      stage_valid <= 1'b1;
      opc_q       <= in_opc;
      rd_q        <= dif.instr[ARQ-OPC_W-1 -: RW];
      rs1_q       <= dif.instr[ARQ-OPC_W-RW-1 -: RW];
      rs2_q       <= dif.instr[ARQ-OPC_W-2*RW-1 -: RW];
      imm_q       <= dif.instr[IMM_W-1:0];
      addr_q      <= dif.instr[ADDR_W-1:0];
      wr_q        <= in_wr;
      ld_q        <= in_ld;
      st_q        <= in_st;
      cmp_q       <= in_cmp;
      jmp_q       <= in_jmp;
    end else if (issue) begin
      stage_valid <= 1'b0;
    end
  end

  assign dif.opcode  = opc_q;
  assign dif.rd      = rd_q;
  assign dif.rs1     = rs1_q;
  assign dif.rs2     = rs2_q;
  assign dif.imm     = imm_q;
  assign dif.addr    = addr_q;
  assign dif.jop_lsb = opc_q[0];
  assign dif.is_wr   = wr_q;
  assign dif.is_ld   = ld_q;
  assign dif.is_st   = st_q;
  assign dif.is_cmp  = cmp_q;
  assign dif.is_jmp  = jmp_q;

`ifdef ID_SCOREBOARD_EN
  logic [NREG-1:0] sb, clr, rd_mask, set_mask;
  logic            flag_pend;

  always_comb begin
    rd_mask = '0;
    case (opc_q)
      OP_LDPX:  rd_mask = NREG'(1) << rs1_q;
      OP_MODEX: rd_mask = (NREG'(1) << rs1_q) | (NREG'(1) << rs2_q);
      OP_STPX:  rd_mask = (NREG'(1) << rd_q) | (NREG'(1) << rs1_q);
      OP_CMPEQ: rd_mask = (NREG'(1) << rs1_q) | (NREG'(1) << rs2_q);
      OP_ADD:   rd_mask = NREG'(1) << rd_q;
      default:  rd_mask = '0;
    endcase
  end

  // same-cycle writeback already counts as released
  assign clr      = dif.wb_en ? (NREG'(1) << dif.wb_reg) : '0;
  assign hazard   = (|(rd_mask & sb & ~clr)) | ((opc_q == OP_JEQ) & flag_pend & ~dif.wb_flag);
  assign set_mask = (issue & wr_q) ? (NREG'(1) << rd_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb        <= '0;
      flag_pend <= 1'b0;
    end else begin
      sb        <= (sb & ~clr) | set_mask;
      flag_pend <= (flag_pend & ~dif.wb_flag) | (issue & cmp_q);
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{dif.wb_en, dif.wb_reg, dif.wb_flag};
  assign hazard    = 1'b0;
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  localparam int ARQ = 16, OPC_W = 3, RW = 3;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  op, rd, rs1, rs2;
    logic [9:0]  imm;
    logic [12:0] addr;
    logic [5:0]  flags; // jop_lsb, wr, ld, st, cmp, jmp
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_decode_if #(.ARQ(ARQ), .OPC_W(OPC_W), .RW(RW)) dif ();
  instr_decode_stage #(.ARQ(ARQ), .OPC_W(OPC_W), .RW(RW)) dut (.clk(clk), .rst(rst), .dif(dif));

  int checks = 0;
  int errors = 0;
  logic [40:0] expq[$];
  vec_t tbl[8];
  vec_t v_set, v_modex, v_cmp, v_j, v_jeq, v_add;

  function automatic vec_t mk(logic [15:0] i, logic [2:0] op, logic [2:0] rd, logic [2:0] rs1,
                              logic [2:0] rs2, logic [9:0] imm, logic [12:0] addr, logic [5:0] fl);
    vec_t v;
    v.instr = i; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.addr = addr; v.flags = fl;
    return v;
  endfunction

  function automatic logic [40:0] pack_exp(vec_t v);
    return {v.op, v.rd, v.rs1, v.rs2, v.imm, v.addr, v.flags};
  endfunction

  function automatic logic [40:0] act_pack();
    return {dif.opcode, dif.rd, dif.rs1, dif.rs2, dif.imm, dif.addr,
            dif.jop_lsb, dif.is_wr, dif.is_ld, dif.is_st, dif.is_cmp, dif.is_jmp};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every issue must match the oldest accepted expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && dif.dec_valid === 1'b1 && dif.dec_ready === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %h expected no issue", act_pack());
      end else begin
        chk("issue_fields", 64'(act_pack()), 64'(expq.pop_front()));
      end
    end
  end

  task automatic send(input vec_t v);
    int n = 0;
    dif.instr_valid = 1'b1;
    dif.instr = v.instr;
    forever begin
      @(negedge clk);
      if (dif.instr_ready === 1'b1 && dif.flush === 1'b0) begin
        expq.push_back(pack_exp(v));
        break;
      end
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got instr_ready=%b expected 1 within 50 cycles", dif.instr_ready);
        break;
      end
    end
    cyc();
    dif.instr_valid = 1'b0;
  endtask

  task automatic clear_inputs();
    dif.instr_valid = 1'b0; dif.instr = '0; dif.flush = 1'b0; dif.dec_ready = 1'b0;
    dif.wb_en = 1'b0; dif.wb_reg = '0; dif.wb_flag = 1'b0;
  endtask

  task automatic do_reset();
    chk("queue_drained", 64'(expq.size()), 64'd0);
    rst = 1'b1;
    clear_inputs();
    cyc();
    rst = 1'b0;
    expq.delete();
    cyc();
  endtask

  // MODEX reading a pending R2 in the stage: stall until writeback of R2 (scoreboard build only).
  task automatic raw_check();
`ifdef ID_SCOREBOARD_EN
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall", {dif.dec_valid, dif.instr_ready}, 2'b00);
      cyc();
    end
    dif.wb_en = 1'b1;
    dif.wb_reg = 3'd2;
    @(negedge clk);
    chk("raw_release", dif.dec_valid, 1'b1);
    cyc();
    dif.wb_en = 1'b0;
`else
    @(negedge clk);
    chk("no_sb_issue", dif.dec_valid, 1'b1);
    cyc();
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(16'h0810, 3'd0, 3'd2, 3'd0, 3'd1, 10'h010, 13'h0810, 6'b010000); // SET
    tbl[1] = mk(16'h2580, 3'd1, 3'd1, 3'd3, 3'd0, 10'h180, 13'h0580, 6'b111000); // LDPX
    tbl[2] = mk(16'h52EA, 3'd2, 3'd4, 3'd5, 3'd6, 10'h2EA, 13'h12EA, 6'b010000); // MODEX
    tbl[3] = mk(16'h7C05, 3'd3, 3'd7, 3'd0, 3'd0, 10'h005, 13'h1C05, 6'b100100); // STPX
    tbl[4] = mk(16'hC005, 3'd6, 3'd0, 3'd0, 3'd0, 10'h005, 13'h0005, 6'b000001); // J
    tbl[5] = mk(16'hA004, 3'd5, 3'd0, 3'd0, 3'd0, 10'h004, 13'h0004, 6'b100001); // JEQ
    tbl[6] = mk(16'hEC0F, 3'd7, 3'd3, 3'd0, 3'd0, 10'h00F, 13'h0C0F, 6'b110000); // ADD
    tbl[7] = mk(16'h82E0, 3'd4, 3'd0, 3'd5, 3'd6, 10'h2E0, 13'h02E0, 6'b000010); // CMPEQ
    v_set   = tbl[0];
    v_j     = tbl[4];
    v_jeq   = tbl[5];
    v_add   = tbl[6];
    v_cmp   = tbl[7];
    v_modex = mk(16'h40A0, 3'd2, 3'd0, 3'd1, 3'd2, 10'h0A0, 13'h00A0, 6'b010000);

    rst = 1'b1;
    clear_inputs();
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {dif.dec_valid, dif.instr_ready, act_pack()}, {1'b0, 1'b1, 41'd0});
    cyc();

    // Streamed table, no register/flag conflicts between entries
    dif.dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(tbl[i]);
    repeat (3) cyc();

    // SET latency, then RAW stall on R2
    do_reset();
    dif.dec_ready = 1'b1;
    send(v_set);
    @(negedge clk);
    chk("set_latency", {dif.dec_valid, dif.opcode, dif.rd, dif.imm, dif.is_wr},
        {1'b1, 3'd0, 3'd2, 10'd16, 1'b1});
    cyc();
    send(v_modex);
    raw_check();

    // Flag hazard: J never stalls, JEQ waits for wb_flag
    do_reset();
    dif.dec_ready = 1'b1;
    send(v_cmp);
    send(v_j);
    @(negedge clk);
    chk("j_no_stall", {dif.dec_valid, dif.jop_lsb}, 2'b10);
    cyc();
    send(v_jeq);
`ifdef ID_SCOREBOARD_EN
    repeat (2) begin
      @(negedge clk);
      chk("jeq_stall", dif.dec_valid, 1'b0);
      cyc();
    end
    dif.wb_flag = 1'b1;
    @(negedge clk);
    chk("jeq_release", {dif.dec_valid, dif.addr, dif.jop_lsb, dif.is_jmp}, {1'b1, 13'd4, 1'b1, 1'b1});
    cyc();
    dif.wb_flag = 1'b0;
`else
    @(negedge clk);
    chk("jeq_no_sb", {dif.dec_valid, dif.addr, dif.jop_lsb, dif.is_jmp}, {1'b1, 13'd4, 1'b1, 1'b1});
    cyc();
`endif

    // Backpressure hold
    do_reset();
    dif.dec_ready = 1'b0;
    send(v_add);
    repeat (3) begin
      @(negedge clk);
      chk("hold_stable", {dif.dec_valid, dif.instr_ready, act_pack()}, {1'b1, 1'b0, pack_exp(v_add)});
      cyc();
    end
    dif.dec_ready = 1'b1;
    @(negedge clk);
    chk("hold_issue", {dif.dec_valid, dif.instr_ready}, 2'b11);
    cyc();

    // Flush drops held and concurrent words, keeps pending R2
    do_reset();
    dif.dec_ready = 1'b1;
    send(v_set);
    @(negedge clk);
    cyc();
    dif.dec_ready = 1'b0;
    send(v_j);
    dif.flush = 1'b1;
    dif.instr_valid = 1'b1;
    dif.instr = 16'hEC0F;
    cyc();
    dif.flush = 1'b0;
    dif.instr_valid = 1'b0;
    void'(expq.pop_back());
    @(negedge clk);
    chk("flush_drop", {dif.dec_valid, dif.instr_ready}, 2'b01);
    cyc();
    dif.dec_ready = 1'b1;
    send(v_modex);
    raw_check();

    // Reset while an instruction is held
    do_reset();
    dif.dec_ready = 1'b1;
    send(v_set);
    @(negedge clk);
    cyc();
    dif.dec_ready = 1'b0;
    send(v_modex);
    @(negedge clk);
    chk("pre_reset_held", dif.instr_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("reset_mid_stall", {dif.dec_valid, act_pack()}, 42'd0);
    cyc();
    rst = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("post_reset_ready", {dif.dec_valid, dif.instr_ready}, 2'b01);
    cyc();
    dif.dec_ready = 1'b1;
    send(v_modex);
    @(negedge clk);
    chk("sb_cleared", dif.dec_valid, 1'b1);
    cyc();
    repeat (2) cyc();

    chk("final_queue_empty", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
